// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: baud codes,
// scheduler FSM states and the power-on baud selection.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_19200  = 2'b00,
    BAUD_38400  = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RECONFIG
  } state_t;

  localparam baud_t DEFAULT_BAUD = BAUD_115200;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first set request searching upward from ptr+1,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int W       = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       ptr,
  output logic [W-1:0]       winner,
  output logic               any_valid
);

  logic [W-1:0] idx;

  // Walk the ring backwards so the nearest hit is written last.
  always_comb begin
    winner    = ptr;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX serializer; owns baud config.
// Define UART_TX_SCHED_TIMEOUT_EN to add the tx_busy-rise timeout.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int         NUM_REQ      = 4,
  parameter  logic [1:0] DEFAULT_BAUD = uart_pkg::DEFAULT_BAUD,
  parameter  int         TIMEOUT_CYC  = 1024,
  localparam int         GW           = $clog2(NUM_REQ)
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cfg_valid,
  input  logic [1:0]           cfg_baud_sel,
  output logic                 cfg_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [1:0]           baud_sel,
  output logic                 baud_rst,
`ifdef UART_TX_SCHED_TIMEOUT_EN
  output logic                 tx_timeout,
`endif
  output logic [GW-1:0]        grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_tx_sched: parameter out of range");
  end

  state_t        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    baud_sel_q, baud_sel_d;
  logic          baud_rst_q, baud_rst_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] winner;
  logic          any_valid;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          to_q, to_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (grant_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    baud_sel_d = baud_sel_q;
    baud_rst_d = 1'b0;
    grant_d    = grant_q;
    req_ready  = '0;
    cfg_ready  = (state_q == ST_IDLE) & ~tx_busy & ~rst;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    to_d       = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Config wins over data in the same cycle.
        if (cfg_valid && cfg_ready) begin
          baud_sel_d = cfg_baud_sel;
          baud_rst_d = 1'b1;
          state_d    = ST_RECONFIG;
        end else if (!tx_busy && any_valid && !rst) begin
          req_ready[winner] = 1'b1;
          tx_data_d  = req_data[{winner, 3'b000} +: 8];
          grant_d    = winner;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (to_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      ST_RECONFIG:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      baud_sel_q <= DEFAULT_BAUD;
      baud_rst_q <= 1'b1;
      grant_q    <= GW'(NUM_REQ - 1);
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt_q   <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      baud_sel_q <= baud_sel_d;
      baud_rst_q <= baud_rst_d;
      grant_q    <= grant_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      to_q       <= to_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign baud_sel = baud_sel_q;
  assign baud_rst = baud_rst_q;
  assign grant_id = grant_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign tx_timeout = to_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a frame-level reference model.
// Define UART_TX_SCHED_TIMEOUT_EN to also exercise the timeout path.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clkin = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_baud_sel = '0;
  logic           cfg_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     baud_sel;
  logic           baud_rst;
  logic [1:0]     grant_id;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic           tx_timeout;
`endif

  uart_tx_sched #(
    .NUM_REQ      (N),
    .DEFAULT_BAUD (2'b11),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clkin        (clkin),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cfg_valid    (cfg_valid),
    .cfg_baud_sel (cfg_baud_sel),
    .cfg_ready    (cfg_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .baud_sel     (baud_sel),
    .baud_rst     (baud_rst),
`ifdef UART_TX_SCHED_TIMEOUT_EN
    .tx_timeout   (tx_timeout),
`endif
    .grant_id     (grant_id)
  );

  initial forever #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr;
  logic [1:0] exp_baud;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clkin);
    #1;
  endtask

  task automatic sample();
    @(negedge clkin);
  endtask

  // Reference: first valid requester after the last grant, wrapping.
  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
  endtask

  task automatic frame(input logic [N-1:0] v, input int rise,
                       input int len, input bit mid_cfg,
                       input logic [1:0] sel);
    int w;
    logic [7:0] d;
    drive_edge();
    req_valid = v;
    rand_data();
    tx_busy = 1'b0;
    sample();
    w = pick(ptr, v);
    d = req_data[8*w +: 8];
    chk("grant_ready", 32'(req_ready), 32'(1) << w);
    chk("cfg_ready_idle", 32'(cfg_ready), 1);
    chk("baud_rst_idle", 32'(baud_rst), 0);
    ptr = w;
    drive_edge();
    tx_busy = (rise == 0);
    sample();
    chk("tx_start", 32'(tx_start), 1);
    chk("tx_data", 32'(tx_data), 32'(d));
    chk("grant_id", 32'(grant_id), w);
    chk("ready_launch", 32'(req_ready), 0);
    for (int i = 0; i < rise + len; i++) begin
      drive_edge();
      tx_busy = (i >= rise);
      req_valid = N'($urandom);
      if (mid_cfg) begin
        cfg_valid = 1'b1;
        cfg_baud_sel = sel;
      end
      sample();
      chk("start_low", 32'(tx_start), 0);
      chk("ready_busy", 32'(req_ready), 0);
      chk("cfg_held", 32'(cfg_ready), 0);
      chk("data_stable", 32'(tx_data), 32'(d));
      chk("baud_unchanged", 32'(baud_sel), 32'(exp_baud));
    end
    drive_edge();
    tx_busy = 1'b0;
    req_valid = '0;
    sample();
    chk("cfg_held_done", 32'(cfg_ready), 0);
    chk("data_stable_done", 32'(tx_data), 32'(d));
    if (mid_cfg) begin
      drive_edge();
      sample();
      chk("cfg_accept", 32'(cfg_ready), 1);
      exp_baud = sel;
      drive_edge();
      cfg_valid = 1'b0;
      sample();
      chk("reconfig_rst", 32'(baud_rst), 1);
      chk("reconfig_sel", 32'(baud_sel), 32'(exp_baud));
    end
  endtask

  task automatic cfg_with_req(input logic [1:0] sel,
                              input logic [N-1:0] v);
    drive_edge();
    cfg_valid = 1'b1;
    cfg_baud_sel = sel;
    req_valid = v;
    sample();
    chk("cfg_pri_ready", 32'(cfg_ready), 1);
    chk("cfg_pri_noreq", 32'(req_ready), 0);
    exp_baud = sel;
    drive_edge();
    cfg_valid = 1'b0;
    sample();
    chk("cfg_pri_rst", 32'(baud_rst), 1);
    chk("cfg_pri_sel", 32'(baud_sel), 32'(exp_baud));
    chk("cfg_pri_wait", 32'(req_ready), 0);
    frame(v, 1, 4, 1'b0, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '1;
    drive_edge();
    drive_edge();
    sample();
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_baud", 32'(baud_sel), 3);
    chk("rst_baud_rst", 32'(baud_rst), 1);
    chk("rst_grant", 32'(grant_id), N - 1);
    drive_edge();
    rst = 1'b0;
    req_valid = '0;
    sample();
    chk("post_rst_cfg", 32'(cfg_ready), 1);
    ptr = N - 1;
    exp_baud = 2'b11;

    frame(4'b0001, 1, 10, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) frame(4'b1111, 1, 10, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) frame(4'b0100, 0, 3, 1'b0, 2'b00);
    frame(4'b1010, 2, 5, 1'b1, 2'b01);
    cfg_with_req(2'b00, 4'b0010);

    for (int i = 0; i < 30; i++)
      frame(N'($urandom_range(1, 15)), $urandom_range(0, 3),
            $urandom_range(1, 10), ($urandom_range(0, 3) == 0),
            2'($urandom));

`ifndef UART_TX_SCHED_TIMEOUT_EN
    frame(4'b0001, 40, 2, 1'b0, 2'b00);
`endif

    cfg_with_req(2'b01, 4'b0100);
    drive_edge();
    req_valid = 4'b1000;
    sample();
    chk("mr_grant", 32'(req_ready), 32'(4'b1000));
    drive_edge();
    req_valid = '0;
    tx_busy = 1'b1;
    sample();
    drive_edge();
    sample();
    drive_edge();
    sample();
    chk("mr_in_frame", 32'(cfg_ready), 0);
    drive_edge();
    rst = 1'b1;
    sample();
    drive_edge();
    rst = 1'b0;
    tx_busy = 1'b0;
    sample();
    chk("mr_idle", 32'(cfg_ready), 1);
    chk("mr_baud", 32'(baud_sel), 3);
    chk("mr_baud_rst", 32'(baud_rst), 1);
    chk("mr_start", 32'(tx_start), 0);
    chk("mr_grant_id", 32'(grant_id), N - 1);
    ptr = N - 1;
    exp_baud = 2'b11;
    frame(4'b0110, 1, 3, 1'b0, 2'b00);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    drive_edge();
    req_valid = 4'b0001;
    sample();
    chk("to_grant", 32'(req_ready), 32'(4'b0001));
    drive_edge();
    req_valid = '0;
    sample();
    chk("to_start", 32'(tx_start), 1);
    for (int i = 0; i < 16; i++) begin
      drive_edge();
      sample();
      chk("to_quiet", 32'(tx_timeout), 0);
      chk("to_waiting", 32'(cfg_ready), 0);
    end
    drive_edge();
    sample();
    chk("to_pulse", 32'(tx_timeout), 1);
    chk("to_idle", 32'(cfg_ready), 1);
    drive_edge();
    sample();
    chk("to_one_cycle", 32'(tx_timeout), 0);
    ptr = 0;
    frame(4'b0011, 1, 3, 1'b0, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one UART transmit serializer between NUM_REQ byte requesters using round-robin arbitration.
- Sequences each frame: grant, start pulse, then waits for the serializer's busy to rise and fall.
- Owns the baud generator configuration. Applies baud_sel changes only between frames and restarts the baud generator with a one-cycle reset pulse.
- Sits between the peripheral request ports and the TX serializer / baud generator pair.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DEFAULT_BAUD, 2'b11: baud_sel value after reset (115200).
- TIMEOUT_CYC, 1024: cycles to wait for tx_busy to rise (used only with UART_TX_SCHED_TIMEOUT_EN).

Ports:
- clkin  in  1  system clock (100 MHz)
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot accept strobe
- cfg_valid  in  1  baud change request
- cfg_baud_sel  in  2  requested baud code (00-19200, 01-38400, 10-57600, 11-115200)
- cfg_ready  out  1  baud change accept
- tx_start  out  1  one-cycle start pulse to serializer
- tx_data  out  8  byte to serializer; stable from tx_start until return to IDLE
- tx_busy  in  1  serializer frame in progress
- baud_sel  out  2  to baud generator
- baud_rst  out  1  baud generator reset
- grant_id  out  $clog2(NUM_REQ)  index of last granted requester

Behaviour:
- Clock and reset: one clock, clkin. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, tx_start=0, tx_data=0, req_ready=0, cfg_ready=0.
  - baud_sel=DEFAULT_BAUD, baud_rst=1.
  - grant_id=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RECONFIG.
- IDLE, baud change path:
  - cfg_ready = (state==IDLE) & ~tx_busy, combinational.
  - On cfg_valid & cfg_ready: baud_sel <= cfg_baud_sel, then go to RECONFIG.
  - Config has priority over data. No req_ready is asserted in that cycle.
- IDLE, data path:
  - Entered when no config is accepted, tx_busy=0 and |req_valid.
  - Winner = first set req_valid bit searching upward from grant_id+1, wrapping modulo NUM_REQ.
  - req_ready[winner]=1, combinational, for that cycle only.
  - Registered updates: tx_data <= req_data[winner], grant_id <= winner. Next state LAUNCH.
- LAUNCH: tx_start=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: stays until tx_busy=1, then WAIT_DONE.
  - tx_busy already high in the LAUNCH cycle is accepted on the first WAIT_BUSY cycle.
- WAIT_DONE: stays until tx_busy=0, then IDLE.
- RECONFIG: baud_rst=1 for exactly one cycle, then IDLE.
- baud_rst, tx_start and tx_data are registered.
- Latency: request accepted in cycle N -> tx_start in cycle N+1. Back-to-back frames use a minimum of 1 IDLE cycle between them.
- Boundary cases:
  - Only one requester valid: it is granted on every frame.
  - Requester drops req_valid before being granted: no effect.
  - cfg_valid while a frame is in flight: held off (cfg_ready=0) until IDLE.
  - rst mid-frame: immediate return to IDLE. baud_sel returns to DEFAULT_BAUD and baud_rst reasserts.
  - tx_busy never rises: without the optional feature, the FSM waits in WAIT_BUSY indefinitely.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined:
  - Adds a counter, cleared on entry to WAIT_BUSY.
  - After TIMEOUT_CYC cycles in WAIT_BUSY with tx_busy=0, the FSM returns to IDLE and pulses output tx_timeout (1 bit, reset 0) for one cycle.
  - The lost byte is not retried.
- Undefined: no counter and no tx_timeout port; WAIT_BUSY waits indefinitely.

Decomposition:
- Package uart_pkg:
  - baud code typedef (enum BAUD_19200..BAUD_115200).
  - FSM state enum.
  - DEFAULT_BAUD constant.
- Sub-module rr_arbiter (NUM_REQ): combinational priority search from a pointer. Returns winner index and any_valid.

Test Plan:
- Reset, then req_valid=4'b0001, data 0x55 -> req_ready=0001 for one cycle, tx_start one cycle later with tx_data=0x55, grant_id=0.
- All four requesters valid continuously, serializer model busy 10 cycles -> grant order 0,1,2,3,0; each req_ready pulse lasts one cycle.
- cfg_valid=1, cfg_baud_sel=2'b00 and req_valid=0010 in the same IDLE cycle -> cfg accepted, baud_sel=00, baud_rst pulses one cycle; data granted the cycle after RECONFIG.
- cfg_valid raised mid-frame -> cfg_ready=0 until tx_busy falls and FSM is in IDLE; baud_sel unchanged until accepted.
- rst asserted in WAIT_DONE -> next cycle state IDLE, baud_sel=11, baud_rst=1, tx_start=0.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, tx_busy held 0 -> tx_timeout pulses once, FSM back in IDLE, next request granted normally.
